// File: rtl/td4_step_ctrl.sv
// Run/step controller for the TD4 core: issues the registered cpu_step enable for halt, divided free-run and single-step.
// Define TD4_BREAKPOINT_EN to build the PC breakpoint (SET_BP/CLR_BP, bp_hit).
module td4_step_ctrl #(
    parameter int DIV_W = 16
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd_op,
    input  logic [DIV_W-1:0] cmd_arg,
    input  logic [3:0]       pc_in,
    output logic             cpu_step,
    output logic [1:0]       state,
    output logic             bp_hit,
    output logic [15:0]      step_count
);

    localparam logic [1:0] ST_HALT = 2'b00;
    localparam logic [1:0] ST_RUN  = 2'b01;
    localparam logic [1:0] ST_STEP = 2'b10;

    localparam logic [2:0] OP_HALT    = 3'b000;
    localparam logic [2:0] OP_RUN     = 3'b001;
    localparam logic [2:0] OP_STEP    = 3'b010;
    localparam logic [2:0] OP_SET_DIV = 3'b011;
`ifdef TD4_BREAKPOINT_EN
    localparam logic [2:0] OP_SET_BP  = 3'b100;
    localparam logic [2:0] OP_CLR_BP  = 3'b101;
`endif

    logic [1:0]       state_reg, state_next;
    logic [DIV_W-1:0] div_reg, div_reg_next;
    logic [DIV_W-1:0] div_cnt_reg, div_cnt_next;
    logic             first_pulse_reg, first_pulse_next;
    logic             cpu_step_reg, cpu_step_next;
    logic [15:0]      step_count_reg, step_count_next;
    logic             cmd_acc;
    logic             bp_match;

`ifdef TD4_BREAKPOINT_EN
    logic [3:0] bp_addr_reg, bp_addr_next;
    logic       bp_arm_reg, bp_arm_next;
    logic       bp_hit_reg, bp_hit_next;

    // first_pulse lets a RUN resumed at the breakpoint PC execute that instruction
    assign bp_match = bp_arm_reg && (pc_in == bp_addr_reg) && !first_pulse_reg;
`else
    logic unused_bp;

    assign bp_match  = 1'b0;
    assign unused_bp = ^{pc_in, first_pulse_reg};
`endif

    assign cmd_acc = cmd_valid && cmd_ready;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_reg       <= ST_HALT;
            div_reg         <= '0;
            div_cnt_reg     <= '0;
            first_pulse_reg <= 1'b0;
            cpu_step_reg    <= 1'b0;
            step_count_reg  <= 16'h0000;
`ifdef TD4_BREAKPOINT_EN
            bp_addr_reg     <= 4'h0;
            bp_arm_reg      <= 1'b0;
            bp_hit_reg      <= 1'b0;
`endif
        end else begin
            state_reg       <= state_next;
            div_reg         <= div_reg_next;
            div_cnt_reg     <= div_cnt_next;
            first_pulse_reg <= first_pulse_next;
            cpu_step_reg    <= cpu_step_next;
            step_count_reg  <= step_count_next;
`ifdef TD4_BREAKPOINT_EN
            bp_addr_reg     <= bp_addr_next;
            bp_arm_reg      <= bp_arm_next;
            bp_hit_reg      <= bp_hit_next;
`endif
        end
    end

    always_comb begin
        state_next       = state_reg;
        div_reg_next     = div_reg;
        div_cnt_next     = div_cnt_reg;
        first_pulse_next = first_pulse_reg;
        cpu_step_next    = 1'b0;
`ifdef TD4_BREAKPOINT_EN
        bp_addr_next     = bp_addr_reg;
        bp_arm_next      = bp_arm_reg;
        bp_hit_next      = bp_hit_reg;
`endif
        // An accepted command always wins over a due RUN pulse
        if (cmd_acc) begin
            case (cmd_op)
                OP_HALT: state_next = ST_HALT;
                OP_RUN: begin
                    div_cnt_next = '0;
                    if (state_reg != ST_RUN) begin
                        state_next       = ST_RUN;
                        first_pulse_next = 1'b1;
`ifdef TD4_BREAKPOINT_EN
                        bp_hit_next      = 1'b0;
`endif
                    end
                end
                OP_STEP: state_next = ST_STEP;
                OP_SET_DIV: begin
                    div_reg_next = cmd_arg;
                    div_cnt_next = '0;
                end
`ifdef TD4_BREAKPOINT_EN
                OP_SET_BP: begin
                    bp_addr_next = cmd_arg[3:0];
                    bp_arm_next  = 1'b1;
                end
                OP_CLR_BP: bp_arm_next = 1'b0;
`endif
                default: ;
            endcase
        end else if (state_reg == ST_STEP) begin
            cpu_step_next = 1'b1;
            state_next    = ST_HALT;
        end else if (state_reg == ST_RUN) begin
            if (div_cnt_reg == div_reg) begin
                div_cnt_next = '0;
                if (bp_match) begin
                    state_next  = ST_HALT;
`ifdef TD4_BREAKPOINT_EN
                    bp_hit_next = 1'b1;
`endif
                end else begin
                    cpu_step_next    = 1'b1;
                    first_pulse_next = 1'b0;
                end
            end else begin
                div_cnt_next = div_cnt_reg + {{(DIV_W-1){1'b0}}, 1'b1};
            end
        end
        step_count_next = step_count_reg + {15'd0, cpu_step_next};
    end

    always_comb begin
        cmd_ready  = (state_reg != ST_STEP);
        state      = state_reg;
        cpu_step   = cpu_step_reg;
        step_count = step_count_reg;
`ifdef TD4_BREAKPOINT_EN
        bp_hit     = bp_hit_reg;
`else
        bp_hit     = 1'b0;
`endif
    end

endmodule

// File: tb/tb_td4_step_ctrl.sv
// Scoreboard bench for td4_step_ctrl: expected cpu_step pulses (edge number, step_count) are queued
// by the stimulus and popped by a monitor whenever the DUT pulses.
module tb_td4_step_ctrl;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [2:0]  cmd_op;
    logic [15:0] cmd_arg;
    logic [3:0]  pc_in;
    logic        cpu_step;
    logic [1:0]  state;
    logic        bp_hit;
    logic [15:0] step_count;

    typedef struct {
        int          edge_n;
        logic [15:0] cnt;
    } exp_t;

    exp_t        exp_q[$];
    int          n_vec  = 0;
    int          n_miss = 0;
    int          cyc    = 0;
    logic [15:0] exp_count = 16'h0000;
    logic [3:0]  pc = 4'h0;
    logic        pc_clr = 1'b0;

    td4_step_ctrl #(.DIV_W(16)) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_op     (cmd_op),
        .cmd_arg    (cmd_arg),
        .pc_in      (pc_in),
        .cpu_step   (cpu_step),
        .state      (state),
        .bp_hit     (bp_hit),
        .step_count (step_count)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    // Minimal TD4 core model: PC advances on every enabled edge
    always @(posedge clock) begin
        if (pc_clr)        pc <= 4'h0;
        else if (cpu_step) pc <= pc + 4'h1;
    end
    assign pc_in = pc;

    always @(negedge clock) begin
        if (reset_n === 1'b1 && cpu_step === 1'b1) begin
            n_vec++;
            if (exp_q.size() == 0) begin
                n_miss++;
                $display("FAIL unexpected_pulse: got pulse at edge %0d step_count=%h, required no pulse", cyc, step_count);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if (cyc != e.edge_n || step_count !== e.cnt) begin
                    n_miss++;
                    $display("FAIL pulse: got edge %0d count %h, required edge %0d count %h",
                             cyc, step_count, e.edge_n, e.cnt);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_miss++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    task automatic expect_pulse(input int edge_n);
        exp_t e;
        exp_count  = exp_count + 16'h0001;
        e.edge_n   = edge_n;
        e.cnt      = exp_count;
        exp_q.push_back(e);
    endtask

    // Called just after a negedge; returns the posedge number at which the command was accepted
    task automatic send(input logic [2:0] op, input logic [15:0] arg, output int acc_edge);
        int guard;
        guard     = 0;
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_arg   = arg;
        while (cmd_ready !== 1'b1 && guard < 20) begin
            @(negedge clock);
            guard++;
        end
        if (guard >= 20) begin
            n_vec++;
            n_miss++;
            $display("FAIL handshake_timeout: got cmd_ready=%b for 20 cycles, required 1", cmd_ready);
        end
        @(negedge clock);
        acc_edge  = cyc;
        cmd_valid = 1'b0;
        $display("cmd op=%b arg=%h accepted at edge %0d state=%b step_count=%h", op, arg, acc_edge, state, step_count);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: got no finish, required finish before 1000000");
        $fatal(1, "timeout");
    end

    initial begin
        int a, b, rel;
        reset_n   = 1'b0;
        cmd_valid = 1'b0;
        cmd_op    = 3'b000;
        cmd_arg   = 16'h0000;
        repeat (3) @(negedge clock);
        check("reset_state", state, 2'b00);
        check("reset_cpu_step", cpu_step, 1'b0);
        check("reset_cmd_ready", cmd_ready, 1'b1);
        check("reset_bp_hit", bp_hit, 1'b0);
        check("reset_step_count", step_count, 16'h0000);
        reset_n = 1'b1;
        rel = cyc;

        // Single step right after reset
        send(3'b010, 16'h0, a);
        check("step_accept_edge", a, rel + 1);
        check("step_state", state, 2'b10);
        expect_pulse(a + 1);
        @(negedge clock);
        check("step_back_to_halt", state, 2'b00);
        check("step_count_1", step_count, 16'h0001);

        // Divided run: period 4
        send(3'b011, 16'd3, a);
        send(3'b001, 16'h0, a);
        check("run_state", state, 2'b01);
        for (int i = 1; i <= 5; i++) expect_pulse(a + 4 * i);
        repeat (20) @(negedge clock);
        send(3'b000, 16'h0, b);
        repeat (8) @(negedge clock);
        check("halt_state", state, 2'b00);
        check("div3_count", step_count, 16'h0006);

        // div 0: pulse every cycle, HALT on a due cycle
        send(3'b011, 16'd0, a);
        send(3'b001, 16'h0, a);
        for (int i = 1; i <= 3; i++) expect_pulse(a + i);
        repeat (3) @(negedge clock);
        send(3'b000, 16'h0, b);
        check("halt_due_edge", b, a + 4);
        repeat (4) @(negedge clock);
        check("div0_count", step_count, 16'h0009);

        // STEP presented while in STEP waits one cycle
        send(3'b010, 16'h0, a);
        expect_pulse(a + 1);
        cmd_valid = 1'b1;
        cmd_op    = 3'b010;
        check("step_busy_ready", cmd_ready, 1'b0);
        send(3'b010, 16'h0, b);
        check("step2_accept_edge", b, a + 2);
        expect_pulse(b + 1);
        repeat (3) @(negedge clock);
        check("step2_count", step_count, 16'h000B);

        // Reserved opcodes only complete the handshake
        send(3'b110, 16'hFFFF, a);
        send(3'b111, 16'hFFFF, a);
        repeat (2) @(negedge clock);
        check("reserved_state", state, 2'b00);

        // Wrap: run to 0xFFFE with div 0, then three single steps
        send(3'b001, 16'h0, a);
        for (int i = 1; i <= 65523; i++) expect_pulse(a + i);
        repeat (65523) @(negedge clock);
        send(3'b000, 16'h0, b);
        check("preload_fffe", step_count, 16'hFFFE);
        for (int i = 0; i < 3; i++) begin
            send(3'b010, 16'h0, a);
            expect_pulse(a + 1);
            @(negedge clock);
            case (i)
                0: check("wrap_ffff", step_count, 16'hFFFF);
                1: check("wrap_0000", step_count, 16'h0000);
                default: check("wrap_0001", step_count, 16'h0001);
            endcase
        end

        // Breakpoint at PC 5, div 1
        send(3'b011, 16'd1, a);
        pc_clr = 1'b1;
        @(negedge clock);
        pc_clr = 1'b0;
        send(3'b100, 16'h0005, a);
`ifdef TD4_BREAKPOINT_EN
        send(3'b001, 16'h0, a);
        for (int i = 1; i <= 5; i++) expect_pulse(a + 2 * i);
        repeat (12) @(negedge clock);
        check("bp_halt_state", state, 2'b00);
        check("bp_halt_pc", pc, 4'h5);
        check("bp_hit_set", bp_hit, 1'b1);
        send(3'b001, 16'h0, b);
        check("bp_hit_cleared", bp_hit, 1'b0);
        for (int i = 1; i <= 3; i++) expect_pulse(b + 2 * i);
        repeat (6) @(negedge clock);
        send(3'b000, 16'h0, a);
        check("bp_resume_pc", pc, 4'h8);
        check("bp_resume_hit", bp_hit, 1'b0);
        send(3'b101, 16'h0, a);
        pc_clr = 1'b1;
        @(negedge clock);
        pc_clr = 1'b0;
`endif
        // Breakpoint absent or cleared: PC runs through 5
        send(3'b001, 16'h0, a);
        for (int i = 1; i <= 6; i++) expect_pulse(a + 2 * i);
        repeat (12) @(negedge clock);
        check("nobp_still_run", state, 2'b01);
        send(3'b000, 16'h0, b);
        check("nobp_pc", pc, 4'h6);
        check("nobp_hit", bp_hit, 1'b0);
        check("nobp_state", state, 2'b00);

        // Asynchronous reset in the middle of a pulse
        send(3'b001, 16'h0, a);
        expect_pulse(a + 2);
        repeat (2) @(negedge clock);
        #2 reset_n = 1'b0;
        #1;
        check("async_rst_cpu_step", cpu_step, 1'b0);
        check("async_rst_count", step_count, 16'h0000);
        check("async_rst_state", state, 2'b00);
        @(negedge clock);
        reset_n = 1'b1;
        exp_count = 16'h0000;
        repeat (6) @(negedge clock);
        check("post_rst_count", step_count, 16'h0000);
        check("queue_drained", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
